ram_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single RAM port between NREQ cache requesters (one dcache + one icache per CPU).

---
 rtl/ram_arbiter_pkg.sv | 38 +++
 rtl/ram_arbiter_rr_picker.sv | 35 +++
 rtl/ram_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ram_arbiter_pkg
//   Shared types for the cache-to-RAM arbitration slice:
//     word_t      - 32-bit data/address word
//     ramstate_t  - state reported by the RAM model
//     arb_state_t - arbiter FSM state (IDLE between bursts, OWN during one)
//   Plus a small index helper used to advance the round-robin pointer.
// ----------------------------------------------------------------------------
package ram_arbiter_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Index that follows i in a ring of n entries (n-1 wraps back to 0).
    function automatic int wrap_inc(input int i, input int n);
        int r;
        if (i >= n - 1) begin
            r = 0;
        end else begin
            r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Scans req starting at position ptr,
//   wrapping modulo N, and reports the first set bit.
//   Ports:
//     req   in  [N-1:0]  request vector
//     ptr   in  [W-1:0]  index with the highest priority this cycle (< N)
//     valid out          at least one request is set
//     idx   out [W-1:0]  first requesting index at or after ptr
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         valid,
    output logic [W-1:0] idx
);

    // Walk the offsets from farthest to nearest so the nearest hit is the
    // last one written and therefore wins.
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = {W{1'b0}};
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j     = ((int'(ptr) + k) >= N) ? (int'(ptr) + k - N) : (int'(ptr) + k);
            valid = valid | req[j];
            idx   = req[j] ? W'(j) : idx;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ----------------------------------------------------------------------------
// ram_arbiter
//   Round-robin arbiter sharing the single RAM port between NREQ cache
//   requesters (index 2c = dcache of core c, 2c+1 = icache of core c).
//   A grant covers a whole burst: the owner keeps the port until the RAM
//   accepts its last word (or it withdraws), so blocks never interleave.
//   Ports:
//     CLK, nRST            clock (rising edge), async reset (active low)
//     req_ren/req_wen      per-requester read / write request
//     req_last             current word is the last of the burst
//     req_addr/req_store   per-requester address / write data
//     req_wait             per-requester stall (0 only on owner's completion)
//     req_load             RAM read data broadcast to all requesters
//     ramREN/ramWEN        RAM read / write enable
//     ramaddr/ramstore     RAM address / write data
//     ramload, ramstate    RAM read data and status
// ----------------------------------------------------------------------------
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int CPUS = 2,
    parameter int NREQ = 2 * CPUS
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic      [NREQ-1:0]   req_ren,
    input  logic      [NREQ-1:0]   req_wen,
    input  logic      [NREQ-1:0]   req_last,
    input  word_t     [NREQ-1:0]   req_addr,
    input  word_t     [NREQ-1:0]   req_store,
    output logic      [NREQ-1:0]   req_wait,
    output word_t                  req_load,
    output logic                   ramREN,
    output logic                   ramWEN,
    output word_t                  ramaddr,
    output word_t                  ramstore,
    input  word_t                  ramload,
    input  ramstate_t              ramstate
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t        state_r;
    arb_state_t        state_next_s;
    logic [OW-1:0]     owner_r;
    logic [OW-1:0]     owner_next_s;
    logic [OW-1:0]     ptr_r;
    logic [OW-1:0]     ptr_next_s;
    logic [NREQ-1:0]   req_s;
    logic              pick_valid_s;
    logic [OW-1:0]     pick_idx_s;
    logic [OW-1:0]     owner_inc_s;
    logic              owner_req_s;
    logic              access_s;

    assign req_s       = req_ren | req_wen;
    assign owner_inc_s = OW'(wrap_inc(int'(owner_r), NREQ));
    assign owner_req_s = req_s[owner_r];
    assign access_s    = (ramstate == ACCESS);

    // Read data is passed straight through; only the owner acts on it.
    assign req_load = ramload;

    rr_picker #(
        .N (NREQ),
        .W (OW)
    ) u_picker (
        .req   (req_s),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // Arbiter state, current owner and round-robin pointer.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r <= IDLE;
            owner_r <= {OW{1'b0}};
            ptr_r   <= {OW{1'b0}};
        end else begin
            state_r <= state_next_s;
            owner_r <= owner_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    // Next-state decisions and RAM/requester-facing outputs.
    always_comb begin
        state_next_s = state_r;
        owner_next_s = owner_r;
        ptr_next_s   = ptr_r;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = {WORD_W{1'b0}};
        ramstore     = {WORD_W{1'b0}};
        req_wait     = {NREQ{1'b1}};

        case (state_r)
            IDLE: begin
                // The grant takes effect next cycle; nothing reaches the RAM
                // while idle, which also gives the one-cycle bubble between
                // bursts.
                if (pick_valid_s) begin
                    owner_next_s = pick_idx_s;
                    state_next_s = OWN;
                end else begin
                    state_next_s = IDLE;
                end
            end

            OWN: begin
                // Write takes precedence when a requester raises both enables.
                ramWEN            = req_wen[owner_r];
                ramREN            = req_ren[owner_r] & ~req_wen[owner_r];
                ramaddr           = req_addr[owner_r];
                ramstore          = req_store[owner_r];
                req_wait[owner_r] = ~access_s;

                if (!owner_req_s) begin
                    // Owner withdrew; any RAM operation in flight is dropped.
                    state_next_s = IDLE;
                    ptr_next_s   = owner_inc_s;
                end else if (access_s && req_last[owner_r]) begin
                    state_next_s = IDLE;
                    ptr_next_s   = owner_inc_s;
                end else begin
                    // Non-ACCESS states (including ERROR) hold the grant.
                    state_next_s = OWN;
                end
            end

            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ram_arbiter
//   Directed bench for ram_arbiter. A behavioural model (busy flag, owner,
//   priority pointer) predicts every output on each falling edge; directed
//   sequences add hand-computed literal expectations.
// ----------------------------------------------------------------------------
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int CPUS = 2;
    localparam int NREQ = 2 * CPUS;

    logic                   CLK  = 1'b0;
    logic                   nRST = 1'b0;
    logic [NREQ-1:0]        req_ren;
    logic [NREQ-1:0]        req_wen;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0][31:0]  req_addr;
    logic [NREQ-1:0][31:0]  req_store;
    logic [NREQ-1:0]        req_wait;
    logic [31:0]            req_load;
    logic                   ramREN;
    logic                   ramWEN;
    logic [31:0]            ramaddr;
    logic [31:0]            ramstore;
    logic [31:0]            ramload;
    ramstate_t              ramstate;

    ram_arbiter #(.CPUS(CPUS), .NREQ(NREQ)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .req_ren   (req_ren),
        .req_wen   (req_wen),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_store (req_store),
        .req_wait  (req_wait),
        .req_load  (req_load),
        .ramREN    (ramREN),
        .ramWEN    (ramWEN),
        .ramaddr   (ramaddr),
        .ramstore  (ramstore),
        .ramload   (ramload),
        .ramstate  (ramstate)
    );

    always #5 CLK = ~CLK;

    int checks_total  = 0;
    int checks_passed = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_ptr   = 0;
    bit n_busy  = 1'b0;
    int n_owner = 0;
    int n_ptr   = 0;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_ptr   <= 0;
        end else begin
            m_busy  <= n_busy;
            m_owner <= n_owner;
            m_ptr   <= n_ptr;
        end
    end

    always @(negedge CLK) begin : cmp
        logic            e_ren, e_wen;
        logic [31:0]     e_addr, e_store;
        logic [NREQ-1:0] e_wait;
        bit              found;
        int              o, c;
        e_ren = 1'b0; e_wen = 1'b0; e_addr = 32'h0; e_store = 32'h0;
        e_wait = {NREQ{1'b1}};
        found = 1'b0;
        n_busy <= m_busy; n_owner <= m_owner; n_ptr <= m_ptr;
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (m_ptr + k) % NREQ;
                if (!found && (req_ren[c] || req_wen[c])) begin
                    found = 1'b1;
                    n_owner <= c;
                    n_busy  <= 1'b1;
                end
            end
        end else begin
            o       = m_owner;
            e_wen   = req_wen[o];
            e_ren   = req_ren[o] && !req_wen[o];
            e_addr  = req_addr[o];
            e_store = req_store[o];
            e_wait[o] = (ramstate != ACCESS);
            if (!(req_ren[o] || req_wen[o]) || (ramstate == ACCESS && req_last[o])) begin
                n_busy <= 1'b0;
                n_ptr  <= (o + 1) % NREQ;
            end
        end
        check("model_ramREN",   {31'h0, ramREN}, {31'h0, e_ren});
        check("model_ramWEN",   {31'h0, ramWEN}, {31'h0, e_wen});
        check("model_ramaddr",  ramaddr, e_addr);
        check("model_ramstore", ramstore, e_store);
        check("model_req_wait", 32'(req_wait), 32'(e_wait));
        check("model_req_load", req_load, ramload);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
        ramload = $urandom;
    endtask

    task automatic clear_reqs();
        req_ren   = {NREQ{1'b0}};
        req_wen   = {NREQ{1'b0}};
        req_last  = {NREQ{1'b0}};
        req_addr  = '{default: 32'h0};
        req_store = '{default: 32'h0};
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        clear_reqs();
        ramstate = FREE;
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    int grants[$];
    int gaps[$];
    int idle_run;
    bit seen;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        clear_reqs();
        ramstate = FREE;
        ramload  = 32'h1234_5678;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;

        // Single icache fetch from requester 1.
        tick();
        req_ren[1] = 1'b1; req_last[1] = 1'b1; req_addr[1] = 32'h100;
        @(negedge CLK);
        check("t2_c1_addr", ramaddr, 32'h0);
        check("t2_c1_wait", 32'(req_wait), 32'hF);
        tick(); ramstate = BUSY;
        @(negedge CLK);
        check("t2_c2_addr", ramaddr, 32'h100);
        check("t2_c2_ren", {31'h0, ramREN}, 32'h1);
        check("t2_c2_wait", 32'(req_wait), 32'hF);
        tick(); ramstate = ACCESS;
        @(negedge CLK);
        check("t2_c3_wait", 32'(req_wait), 32'hD);
        tick(); clear_reqs(); ramstate = FREE;
        @(negedge CLK);
        check("t2_c4_ren", {31'h0, ramREN}, 32'h0);
        check("t2_c4_wait", 32'(req_wait), 32'hF);

        // Reset in the middle of a burst owned by requester 2.
        tick();
        req_ren[2] = 1'b1; req_addr[2] = 32'h2000; ramstate = BUSY;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        check("t1_own_addr", ramaddr, 32'h2000);
        check("t1_own_ren", {31'h0, ramREN}, 32'h1);
        @(posedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        check("t1_rst_ren", {31'h0, ramREN}, 32'h0);
        check("t1_rst_wen", {31'h0, ramWEN}, 32'h0);
        check("t1_rst_wait", 32'(req_wait), 32'hF);
        check("t1_rst_addr", ramaddr, 32'h0);
        @(posedge CLK);
        #1;
        clear_reqs();
        req_ren[0] = 1'b1; req_last[0] = 1'b1; req_addr[0] = 32'h3000;
        req_ren[3] = 1'b1; req_last[3] = 1'b1; req_addr[3] = 32'h3300;
        nRST = 1'b1;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        check("t1_grant_addr", ramaddr, 32'h3000);
        tick(); ramstate = ACCESS;
        @(negedge CLK);
        check("t1_grant_wait", 32'(req_wait), 32'hE);
        tick(); clear_reqs(); ramstate = FREE;
        @(negedge CLK);

        // Four-way contention, single-word bursts, RAM always ready.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_ren[i]  = 1'b1;
            req_last[i] = 1'b1;
            req_addr[i] = 32'h1000 + 32'(i * 4);
        end
        ramstate = ACCESS;
        idle_run = 0;
        seen     = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge CLK);
            if (ramREN) begin
                grants.push_back(int'((ramaddr - 32'h1000) >> 2));
                if (seen) gaps.push_back(idle_run);
                seen     = 1'b1;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            if (cyc < 9) tick();
        end
        check("t3_grant_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check("t3_grant_order", (i < grants.size()) ? 32'(grants[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
        end
        for (int i = 0; i < 4; i++) begin
            check("t3_idle_gap", (i < gaps.size()) ? 32'(gaps[i]) : 32'hFFFF_FFFF, 32'd1);
        end
        tick(); clear_reqs(); ramstate = FREE;

        // Two-word dcache0 write must finish before icache1 is granted.
        do_reset();
        req_wen[0] = 1'b1; req_addr[0] = 32'h200; req_store[0] = 32'hAAAA_0001;
        req_ren[1] = 1'b1; req_addr[1] = 32'h300; req_last[1] = 1'b1;
        ramstate = BUSY;
        @(negedge CLK);
        check("t4_idle_wen", {31'h0, ramWEN}, 32'h0);
        tick();
        @(negedge CLK);
        check("t4_w1_addr", ramaddr, 32'h200);
        check("t4_w1_store", ramstore, 32'hAAAA_0001);
        check("t4_w1_wen", {31'h0, ramWEN}, 32'h1);
        tick(); ramstate = ACCESS;
        @(negedge CLK);
        check("t4_w1_wait", 32'(req_wait), 32'hE);
        tick();
        req_addr[0] = 32'h204; req_store[0] = 32'hAAAA_0002; req_last[0] = 1'b1;
        ramstate = BUSY;
        @(negedge CLK);
        check("t4_w2_addr", ramaddr, 32'h204);
        check("t4_w2_store", ramstore, 32'hAAAA_0002);
        check("t4_w2_wait", 32'(req_wait), 32'hF);
        tick(); ramstate = ACCESS;
        @(negedge CLK);
        check("t4_w2_done", 32'(req_wait), 32'hE);
        tick(); req_wen[0] = 1'b0; req_last[0] = 1'b0; ramstate = BUSY;
        @(negedge CLK);
        check("t4_bubble_ren", {31'h0, ramREN}, 32'h0);
        check("t4_bubble_wen", {31'h0, ramWEN}, 32'h0);
        tick();
        @(negedge CLK);
        check("t4_i1_addr", ramaddr, 32'h300);
        check("t4_i1_ren", {31'h0, ramREN}, 32'h1);
        tick(); ramstate = ACCESS;
        @(negedge CLK);
        check("t4_i1_wait", 32'(req_wait), 32'hD);
        tick(); clear_reqs(); ramstate = FREE;

        // Requester 2 raises both enables: the write wins.
        req_ren[2] = 1'b1; req_wen[2] = 1'b1; req_last[2] = 1'b1;
        req_addr[2] = 32'h40; req_store[2] = 32'h5555_AAAA;
        ramstate = ACCESS;
        @(negedge CLK);
        tick();
        @(negedge CLK);
        check("t5_wen", {31'h0, ramWEN}, 32'h1);
        check("t5_ren", {31'h0, ramREN}, 32'h0);
        check("t5_addr", ramaddr, 32'h40);
        check("t5_store", ramstore, 32'h5555_AAAA);
        check("t5_wait", 32'(req_wait), 32'hB);
        tick(); clear_reqs(); ramstate = FREE;

        // ERROR holds the grant; then one word completes; then owner drops.
        req_ren[3] = 1'b1; req_addr[3] = 32'h80; ramstate = ERROR;
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge CLK);
            check("t6_err_wait", {31'h0, req_wait[3]}, 32'h1);
            check("t6_err_addr", ramaddr, 32'h80);
        end
        tick(); ramstate = ACCESS;
        @(negedge CLK);
        check("t6_access_wait", {31'h0, req_wait[3]}, 32'h0);
        tick(); req_addr[3] = 32'h84; ramstate = BUSY;
        @(negedge CLK);
        check("t6_w2_addr", ramaddr, 32'h84);
        check("t6_w2_wait", {31'h0, req_wait[3]}, 32'h1);
        tick(); req_ren[3] = 1'b0;
        @(negedge CLK);
        check("t6_drop_ren", {31'h0, ramREN}, 32'h0);
        tick();
        req_ren[0] = 1'b1; req_last[0] = 1'b1; req_addr[0] = 32'h500;
        @(negedge CLK);
        check("t6_idle_ren", {31'h0, ramREN}, 32'h0);
        check("t6_idle_wait", 32'(req_wait), 32'hF);
        tick();
        @(negedge CLK);
        check("t6_wrap_addr", ramaddr, 32'h500);
        tick(); clear_reqs(); ramstate = FREE;
        repeat (3) tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
